// File: rtl/ram16_stream_reader.sv
// rtl/ram16_stream_reader.sv - block reader for the RAM16 buffer, streams words out via a credit-controlled FIFO
module ram16_stream_reader #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W:0]     len_r, issued, len_clamped;
  logic [RD_LATENCY-1:0] vpipe, lpipe;
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_count, in_flight;
  logic                issue, issue_last, push, pop, start_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign len_clamped = (length > MAX_LEN) ? MAX_LEN : length;
  assign start_ok    = (state == IDLE) && start;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + CNT_W'(vpipe[i]);
    end
  end

  // Credit check: reads in flight already own a FIFO slot; a pop this cycle is not counted.
  assign issue      = (state == RUN) && (issued < len_r) &&
                      ((in_flight + fifo_count) < CNT_W'(FIFO_DEPTH));
  assign issue_last = issue && (issued == len_r - 1'b1);
  assign push       = vpipe[RD_LATENCY-1];
  assign pop        = out_valid && out_ready;

  assign out_valid  = (fifo_count != '0);
  assign out_data   = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last   = out_valid && fifo_last[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = (len_clamped == '0) ? DONE : RUN;
      RUN:     if (pop && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_r       <= '0;
      issued      <= '0;
      ram_address <= '0;
      vpipe       <= '0;
      lpipe       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      if (start_ok) begin
        len_r       <= len_clamped;
        issued      <= '0;
        ram_address <= base_addr;
      end else if (issue) begin
        ram_address <= ram_address + 1'b1;
        issued      <= issued + 1'b1;
      end
      vpipe <= RD_LATENCY'({vpipe, issue});
      lpipe <= RD_LATENCY'({lpipe, issue_last});
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: out_data/out_last are gated by out_valid.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= ram_q;
      fifo_last[wr_ptr] <= lpipe[RD_LATENCY-1];
    end
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));

endmodule
